// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner controller and its buffer-occupancy counter:
// state codes, default occupancy levels and the counter command encoding.
package scanner_pkg;

  localparam int CNT_W_DEF     = 8;
  localparam int HALF_LVL_DEF  = 50;
  localparam int READY_LVL_DEF = 80;
  localparam int PEER_LVL_DEF  = 90;
  localparam int FULL_LVL_DEF  = 100;

  // Codes are visible on the debug/LED port, so they are fixed explicitly.
  typedef enum logic [2:0] {
    S_LOW_POWER = 3'd0,
    S_IDLE      = 3'd1,
    S_SCANNING  = 3'd2,
    S_WAIT_XFER = 3'd3,
    S_TRANSFER  = 3'd4,
    S_FLUSH     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_DEC  = 2'b01,
    CMD_INC  = 2'b10,
    CMD_DUMP = 2'b11
  } cmd_e;

  // The counter samples one command per slow tick, so each state owns exactly one command.
  function automatic cmd_e state_cmd(input state_e s);
    case (s)
      S_SCANNING: return CMD_INC;
      S_TRANSFER: return CMD_DEC;
      S_FLUSH:    return CMD_DUMP;
      default:    return CMD_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/scanner_ctrl_level_oneshot.sv
// Threshold one-shot: one registered pulse the first time count reaches LEVEL while
// enabled, then silent until clr re-arms it.
module level_oneshot #(
  parameter int CNT_W = 8,
  parameter int LEVEL = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] count,
  output logic             pulse
);

  localparam logic [CNT_W-1:0] LEVEL_C = CNT_W'(LEVEL);

  logic fired_q;
  logic hit;

  assign hit = en && !fired_q && (count >= LEVEL_C);

  // NOTE: flops are written with <= so every register samples pre-edge values,
  // independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fired_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      pulse <= hit;
      if (clr)      fired_q <= 1'b0;
      else if (hit) fired_q <= 1'b1;
    end
  end

endmodule

// File: rtl/scanner_ctrl.sv
// Per-scanner control FSM: commands the buffer-occupancy counter and turns its
// data_count into peer (wake/go) and host (ready/done) handshakes.
module scanner_ctrl
  import scanner_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int HALF_LVL  = HALF_LVL_DEF,
  parameter int READY_LVL = READY_LVL_DEF,
  parameter int PEER_LVL  = PEER_LVL_DEF,
  parameter int FULL_LVL  = FULL_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power_on,
  input  logic             start_req,
  input  logic             xfer_grant,
  input  logic             flush_req,
  input  logic [CNT_W-1:0] data_count,
  output logic             scanning,
  output logic             transfer,
  output logic             flush,
  output logic             low_power,
  output logic             wake_peer,
  output logic             peer_go,
  output logic             ready_xfer,
  output logic             done,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] READY_C = CNT_W'(READY_LVL);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FULL_LVL);

  state_e state_q, state_d;
  cmd_e   cmd_d;
  logic   clr_flags;
  logic   done_d;
  logic   in_scan;
  logic   is_full, is_empty, is_ready;

  assign is_full  = data_count >= FULL_C;   // anything past saturation counts as full
  assign is_empty = data_count == '0;
  assign is_ready = data_count >= READY_C;
  assign in_scan  = state_q == S_SCANNING;

  // Priority flush_req > xfer_grant > start_req falls out of the if/else order.
  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_flags = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_LOW_POWER: begin
        if (power_on) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (flush_req) state_d = S_FLUSH;
        else if (start_req) begin
          state_d   = S_SCANNING;
          clr_flags = 1'b1;
        end
      end
      S_SCANNING: begin
        if (flush_req)                     state_d = S_FLUSH;
        else if (xfer_grant && ready_xfer) state_d = S_TRANSFER;
        else if (is_full)                  state_d = S_WAIT_XFER;
      end
      S_WAIT_XFER: begin
        if (flush_req)       state_d = S_FLUSH;
        else if (xfer_grant) state_d = S_TRANSFER;
      end
      S_TRANSFER: begin
        if (flush_req) state_d = S_FLUSH;
        else if (is_empty) begin
          state_d = S_LOW_POWER;
          done_d  = 1'b1;
        end
      end
      S_FLUSH: begin
        if (is_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_LOW_POWER;
    endcase
  end

  assign cmd_d = state_cmd(state_d);

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_LOW_POWER;
      scanning   <= 1'b0;
      transfer   <= 1'b0;
      flush      <= 1'b0;
      low_power  <= 1'b1;
      ready_xfer <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      scanning   <= cmd_d == CMD_INC;
      transfer   <= cmd_d == CMD_DEC;
      flush      <= cmd_d == CMD_DUMP;
      low_power  <= state_d == S_LOW_POWER;
      ready_xfer <= is_ready && (state_d == S_SCANNING || state_d == S_WAIT_XFER);
      done       <= done_d;
    end
  end

  assign state = state_q;

  level_oneshot #(
    .CNT_W (CNT_W),
    .LEVEL (HALF_LVL)
  ) u_wake (
    .clk   (clk),
    .rst   (rst),
    .en    (in_scan),
    .clr   (clr_flags),
    .count (data_count),
    .pulse (wake_peer)
  );

  level_oneshot #(
    .CNT_W (CNT_W),
    .LEVEL (PEER_LVL)
  ) u_go (
    .clk   (clk),
    .rst   (rst),
    .en    (in_scan),
    .clr   (clr_flags),
    .count (data_count),
    .pulse (peer_go)
  );

endmodule
